csa_result_packer: RTL and testbench
====================================

// Module: csa_result_packer
// PURPOSE
//  Downstream stage of the CSA stream-cypher core. Captures each 48-bit CSA result on the
//  rising edge of the core's ready strobe, packs result pairs into three 32-bit words and
//  buffers them in a FIFO. The AXI register logic drains the FIFO one word per read.
//  Tracks item count against an expected total and raises done once the run is fully buffered.
// PARAMETERS
//  FIFO_AW     6    FIFO address width; depth = 2**FIFO_AW words
//  DATA_W      32   word width; fixed at 32, other values unsupported
// PORTS
//  fpga_clk        in   1          single clock for the whole block
//  rst_n           in   1          asynchronous active-low reset
//  clear           in   1          sync clear (pulsed with STEP_REQ_STUFF); same effect as reset
//  item_total      in   16         expected result count for this run; 0 = no done tracking
//  res_valid       in   1          CSA ready strobe; capture on rising edge only
//  res_data        in   48         CSA result (byte_ram_out), valid while res_valid high
//  rd_en           in   1          pop one word
//  rd_data         out  DATA_W     popped word, registered
//  rd_valid        out  1          1-cycle pulse: rd_data updated by a successful pop
//  fifo_count      out  FIFO_AW+1  words currently stored
//  empty / full    out  1          FIFO status
//  overflow        out  1          sticky: a push was dropped because FIFO was full
//  underflow       out  1          sticky: rd_en while empty
//  items_captured  out  16         results accepted since clear
//  done            out  1          run complete and flushed; held until clear
// BEHAVIOUR
//  - Reset and clear: all outputs 0 except empty=1. Pointers, phase, flags and prev_valid are 0.
//    Clear overrides a same-cycle capture, push or pop.
//  - Capture when res_valid & ~prev_valid and ~done. prev_valid is a register, so two
//    captures are always at least 2 cycles apart.
//  - Packer FSM, states P0 (nothing pending), P1 (16b pending), P1W (second word owed):
//    P0 on capture A: push A[31:0] at end of cycle N, store A[47:32], go to P1.
//    P1 on capture B: push {B[15:0],pend} at end of N, latch B[47:16], go to P1W.
//    P1W: push the latched word at end of N+1, go to P0.
//    Word order for a pair: A[31:0], {B[15:0],A[47:32]}, B[47:16].
//  - items_captured increments on each capture, saturating at 16'hFFFF.
//  - Flush: if item_total!=0 and items_captured==item_total in state P1, push
//    {16'h0, pend} on the next cycle and go to P0.
//  - done asserts the cycle after the final push: state P0, count==total, total!=0.
//    While done=1, rising edges on res_valid are ignored.
//  - FIFO write latency: a word pushed at the end of cycle N is reflected in empty/fifo_count
//    in cycle N+1.
//  - Read latency: rd_en in cycle N pops; rd_data and rd_valid update at end of N.
//    On empty: no pop, rd_data holds its value, underflow sets.
//  - Full is judged on the pre-cycle state. A push while full is dropped and sets overflow,
//    even if a pop occurs in the same cycle. The packer still advances, so it never stalls.
//  - Simultaneous push and pop when not full and not empty: count is unchanged.
//  - Pointers wrap modulo depth. Full = count==2**FIFO_AW.
// STRUCTURE
//  - csa_pkg holds: CSA_RES_W=48, CSA_WORD_W=32, packer state encodings (P0/P1/P1W).
//  - One sub-module, csa_sync_fifo: single-clock FIFO with registered read and count output,
//    and full/empty status.
//  - The packer FSM and counters live in this file.
// TESTING
//  1 Single pair: total=2, results 0x111122223333 then 0xAAAABBBBCCCC
//    -> words 0x22223333, 0xCCCC1111, 0xAAAABBBB; done=1.
//  2 Odd flush: total=1, result 0x0123456789AB -> words 0x456789AB, 0x00000123;
//    done the cycle after the second push.
//  3 Edge detect: res_valid held high for 5 cycles -> one capture only, items_captured=1.
//  4 Overflow: FIFO_AW=2, 4 results with no reads -> fifo_count=4, overflow=1,
//    first 4 words intact.
//  5 Empty read: rd_en with empty=1 -> underflow=1, rd_valid=0, rd_data unchanged.
//  6 Reset and clear mid-run: clear asserted in P1W, or rst_n asserted async mid-push
//    -> empty=1, count=0, done=0. Next run packs from P0 correctly.

Source files
------------

// File: rtl/csa_pkg.sv
// Shared widths and packer state encodings for the CSA result path.
package csa_pkg;
    localparam int CSA_RES_W  = 48;
    localparam int CSA_WORD_W = 32;
    localparam int CSA_HALF_W = 16;

    typedef enum logic [1:0] {
        P0  = 2'd0,
        P1  = 2'd1,
        P1W = 2'd2
    } pack_state_t;
endpackage

// File: rtl/csa_sync_fifo.sv
// Single-clock FIFO with a registered read port, an occupancy count and sticky error flags.
module csa_sync_fifo #(
    parameter int AW     = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [AW:0]       count,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              underflow
);
    localparam logic [AW:0] DEPTH_CNT = {1'b1, {AW{1'b0}}};

    logic [DATA_W-1:0] mem [1<<AW];
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic              wr_ok;
    logic              rd_ok;

    assign empty = (count == '0);
    assign full  = (count == DEPTH_CNT);
    // Full/empty come from registered state, so a push while full is dropped even with a pop.
    assign wr_ok = push & ~full;
    assign rd_ok = pop & ~empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
        end else if (clear) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
        end else begin
            if (wr_ok) wptr <= wptr + AW'(1);
            if (rd_ok) begin
                rptr    <= rptr + AW'(1);
                rd_data <= mem[rptr];
            end
            rd_valid <= rd_ok;
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            overflow  <= overflow  | (push & full);
            underflow <= underflow | (pop & empty);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok && !clear) mem[wptr] <= push_data;
    end
endmodule

// File: rtl/csa_result_packer.sv
// Captures 48-bit CSA results on the strobe's rising edge, packs pairs into three 32-bit words.
module csa_result_packer
    import csa_pkg::*;
#(
    parameter int FIFO_AW = 6,
    parameter int DATA_W  = 32
) (
    input  logic                 fpga_clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic [15:0]          item_total,
    input  logic                 res_valid,
    input  logic [CSA_RES_W-1:0] res_data,
    input  logic                 rd_en,
    output logic [DATA_W-1:0]    rd_data,
    output logic                 rd_valid,
    output logic [FIFO_AW:0]     fifo_count,
    output logic                 empty,
    output logic                 full,
    output logic                 overflow,
    output logic                 underflow,
    output logic [15:0]          items_captured,
    output logic                 done
);
    pack_state_t            state;
    pack_state_t            state_nxt;
    logic                   prev_valid;
    logic                   done_reg;
    logic                   done_now;
    logic                   capture;
    logic                   flush;
    logic                   push;
    logic [DATA_W-1:0]      push_data;
    logic [CSA_HALF_W-1:0]  pend;
    logic [CSA_WORD_W-1:0]  owed;

    assign done_now = (state == P0) && (item_total != 16'd0) && (items_captured == item_total);
    assign done     = done_reg | done_now;
    assign capture  = res_valid & ~prev_valid & ~done;
    // An odd final result leaves 16 bits pending; drain them zero-padded.
    assign flush    = (state == P1) && (item_total != 16'd0) && (items_captured == item_total);

    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        push_data = '0;
        case (state)
            P0: if (capture) begin
                push      = 1'b1;
                push_data = res_data[31:0];
                state_nxt = P1;
            end
            P1: if (capture) begin
                push      = 1'b1;
                push_data = {res_data[15:0], pend};
                state_nxt = P1W;
            end else if (flush) begin
                push      = 1'b1;
                push_data = {16'h0000, pend};
                state_nxt = P0;
            end
            P1W: begin
                push      = 1'b1;
                push_data = owed;
                state_nxt = P0;
            end
            default: state_nxt = P0;
        endcase
    end

    always_ff @(posedge fpga_clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= P0;
            prev_valid     <= 1'b0;
            done_reg       <= 1'b0;
            items_captured <= '0;
        end else if (clear) begin
            state          <= P0;
            prev_valid     <= 1'b0;
            done_reg       <= 1'b0;
            items_captured <= '0;
        end else begin
            state      <= state_nxt;
            prev_valid <= res_valid;
            done_reg   <= done_reg | done_now;
            if (capture && items_captured != 16'hFFFF) items_captured <= items_captured + 16'd1;
        end
    end

    always_ff @(posedge fpga_clk) begin
        if (capture && state == P0) pend <= res_data[47:32];
        if (capture && state == P1) owed <= res_data[47:16];
    end

    csa_sync_fifo #(
        .AW     (FIFO_AW),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk       (fpga_clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .push      (push),
        .push_data (push_data),
        .pop       (rd_en),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .count     (fifo_count),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow)
    );
endmodule

// File: tb/tb_csa_result_packer.sv
// Randomized and directed bench for csa_result_packer against a word-list reference model.
module tb_csa_result_packer;
    logic        fpga_clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic [15:0] item_total;
    logic        res_valid;
    logic [47:0] res_data;
    logic        rd_en;

    logic [31:0] rd_data;
    logic        rd_valid;
    logic [6:0]  fifo_count;
    logic        empty, full, overflow, underflow, done;
    logic [15:0] items_captured;

    logic [31:0] s_rd_data;
    logic        s_rd_valid;
    logic [2:0]  s_fifo_count;
    logic        s_empty, s_full, s_overflow, s_underflow, s_done;
    logic [15:0] s_items_captured;

    int total_n = 0;
    int bad_n   = 0;

    logic [47:0] res_arr [16];
    logic [31:0] exp_q [$];

    always #5 fpga_clk = ~fpga_clk;

    csa_result_packer #(.FIFO_AW(6), .DATA_W(32)) dut (
        .fpga_clk(fpga_clk), .rst_n(rst_n), .clear(clear), .item_total(item_total),
        .res_valid(res_valid), .res_data(res_data), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid), .fifo_count(fifo_count),
        .empty(empty), .full(full), .overflow(overflow), .underflow(underflow),
        .items_captured(items_captured), .done(done)
    );

    csa_result_packer #(.FIFO_AW(2), .DATA_W(32)) dut_small (
        .fpga_clk(fpga_clk), .rst_n(rst_n), .clear(clear), .item_total(item_total),
        .res_valid(res_valid), .res_data(res_data), .rd_en(rd_en),
        .rd_data(s_rd_data), .rd_valid(s_rd_valid), .fifo_count(s_fifo_count),
        .empty(s_empty), .full(s_full), .overflow(s_overflow), .underflow(s_underflow),
        .items_captured(s_items_captured), .done(s_done)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total_n++;
        if (got !== exp) begin
            bad_n++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge fpga_clk);
        #1;
    endtask

    task automatic send(input logic [47:0] d, input int hi, input int lo);
        res_data  = d;
        res_valid = 1'b1;
        repeat (hi) tick();
        res_valid = 1'b0;
        repeat (lo) tick();
    endtask

    task automatic do_clear(input logic [15:0] tot);
        item_total = tot;
        clear      = 1'b1;
        tick();
        clear      = 1'b0;
    endtask

    task automatic pop_chk(input string tag, input logic [31:0] exp);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk({tag, "_vld"}, 64'(rd_valid), 64'(1));
        chk(tag, 64'(rd_data), 64'(exp));
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 40 && !done; i++) tick();
        chk(tag, 64'(done), 64'(1));
    endtask

    // Reference: results taken in pairs, odd tail zero-padded.
    task automatic model_build(input int n);
        logic [47:0] a, b;
        exp_q.delete();
        for (int i = 0; i < n; i += 2) begin
            a = res_arr[i];
            exp_q.push_back(a[31:0]);
            if (i + 1 < n) begin
                b = res_arr[i+1];
                exp_q.push_back({b[15:0], a[47:32]});
                exp_q.push_back(b[47:16]);
            end else begin
                exp_q.push_back({16'h0000, a[47:32]});
            end
        end
    endtask

    task automatic run_pair_check(input string tag);
        res_arr[0] = 48'h1111_2222_3333;
        res_arr[1] = 48'hAAAA_BBBB_CCCC;
        model_build(2);
        send(res_arr[0], 1, 1);
        send(res_arr[1], 1, 1);
        wait_done({tag, "_done"});
        chk({tag, "_cnt"}, 64'(fifo_count), 64'(3));
        chk({tag, "_items"}, 64'(items_captured), 64'(2));
        for (int i = 0; i < 3; i++) pop_chk({tag, "_word"}, exp_q[i]);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout total=%0d bad=%0d", total_n, bad_n);
        $fatal(1);
    end

    initial begin
        int n, nw;
        rst_n = 1'b0; clear = 1'b0; item_total = 16'd0;
        res_valid = 1'b0; res_data = '0; rd_en = 1'b0;
        repeat (3) @(posedge fpga_clk);
        #2 rst_n = 1'b1;
        tick();

        chk("rst_empty", 64'(empty), 64'(1));
        chk("rst_full", 64'(full), 64'(0));
        chk("rst_count", 64'(fifo_count), 64'(0));
        chk("rst_ovf", 64'(overflow), 64'(0));
        chk("rst_unf", 64'(underflow), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_items", 64'(items_captured), 64'(0));
        chk("rst_rdvld", 64'(rd_valid), 64'(0));
        chk("rst_rddata", 64'(rd_data), 64'(0));

        // Single pair
        do_clear(16'd2);
        run_pair_check("pair");
        chk("pair_empty", 64'(empty), 64'(1));

        // Empty read keeps last word
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("unf_flag", 64'(underflow), 64'(1));
        chk("unf_rdvld", 64'(rd_valid), 64'(0));
        chk("unf_rddata", 64'(rd_data), 64'h0000_0000_AAAA_BBBB);

        // Odd flush with exact done timing
        do_clear(16'd1);
        chk("clr_unf", 64'(underflow), 64'(0));
        res_data  = 48'h0123_4567_89AB;
        res_valid = 1'b1;
        tick();
        res_valid = 1'b0;
        chk("odd_cnt1", 64'(fifo_count), 64'(1));
        chk("odd_done_early", 64'(done), 64'(0));
        tick();
        chk("odd_cnt2", 64'(fifo_count), 64'(2));
        chk("odd_done", 64'(done), 64'(1));
        pop_chk("odd_w0", 32'h4567_89AB);
        pop_chk("odd_w1", 32'h0000_0123);

        // Edge detect: held strobe captures once
        do_clear(16'd5);
        send(48'h0000_1234_5678, 5, 2);
        chk("edge_items", 64'(items_captured), 64'(1));
        chk("edge_cnt", 64'(fifo_count), 64'(1));

        // Overflow on the depth-4 instance
        do_clear(16'd0);
        for (int i = 0; i < 4; i++) res_arr[i] = {16'($urandom), $urandom};
        model_build(4);
        for (int i = 0; i < 4; i++) send(res_arr[i], 1, 1);
        tick();
        chk("ovf_cnt", 64'(s_fifo_count), 64'(4));
        chk("ovf_full", 64'(s_full), 64'(1));
        chk("ovf_flag", 64'(s_overflow), 64'(1));
        chk("ovf_big_flag", 64'(overflow), 64'(0));
        chk("ovf_big_cnt", 64'(fifo_count), 64'(6));
        for (int i = 0; i < 4; i++) begin
            rd_en = 1'b1;
            tick();
            rd_en = 1'b0;
            chk("ovf_word", 64'(s_rd_data), 64'(exp_q[i]));
        end

        // Clear while the second word is owed
        do_clear(16'd2);
        send(48'h5555_6666_7777, 1, 1);
        res_data  = 48'h8888_9999_AAAA;
        res_valid = 1'b1;
        tick();
        res_valid = 1'b0;
        clear     = 1'b1;
        tick();
        clear     = 1'b0;
        chk("clr_empty", 64'(empty), 64'(1));
        chk("clr_cnt", 64'(fifo_count), 64'(0));
        chk("clr_done", 64'(done), 64'(0));
        chk("clr_items", 64'(items_captured), 64'(0));
        tick();
        run_pair_check("postclr");

        // Asynchronous reset in the middle of a pair
        do_clear(16'd2);
        send(48'h5555_6666_7777, 1, 1);
        res_data  = 48'h8888_9999_AAAA;
        res_valid = 1'b1;
        @(posedge fpga_clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_empty", 64'(empty), 64'(1));
        chk("arst_cnt", 64'(fifo_count), 64'(0));
        chk("arst_done", 64'(done), 64'(0));
        chk("arst_items", 64'(items_captured), 64'(0));
        res_valid = 1'b0;
        #3 rst_n = 1'b1;
        tick();
        run_pair_check("postrst");

        // Randomized runs
        for (int r = 0; r < 8; r++) begin
            n = $urandom_range(1, 9);
            do_clear(16'(n));
            for (int i = 0; i < n; i++) res_arr[i] = {16'($urandom), $urandom};
            model_build(n);
            for (int i = 0; i < n; i++)
                send(res_arr[i], $urandom_range(1, 3), $urandom_range(1, 3));
            wait_done("rnd_done");
            nw = exp_q.size();
            chk("rnd_items", 64'(items_captured), 64'(n));
            chk("rnd_cnt", 64'(fifo_count), 64'(nw));
            send({16'($urandom), $urandom}, 1, 2);
            chk("rnd_ign_items", 64'(items_captured), 64'(n));
            chk("rnd_ign_cnt", 64'(fifo_count), 64'(nw));
            chk("rnd_done_held", 64'(done), 64'(1));
            for (int i = 0; i < nw; i++) pop_chk("rnd_word", exp_q[i]);
            chk("rnd_empty", 64'(empty), 64'(1));
        end

        $display("test done: total=%0d bad=%0d", total_n, bad_n);
        $finish;
    end
endmodule
